// File: rtl/debug_scan_unit_pkg.sv
// Shared types for the debug scan unit: scan target, FSM state codes and checksum step.
package debug_scan_unit_pkg;

    typedef enum logic {
        SCAN_RF = 1'b0,
        SCAN_DF = 1'b1
    } scan_mode_t;

    typedef logic [1:0] scan_state_t;
    localparam scan_state_t IDLE  = 2'd0;
    localparam scan_state_t ISSUE = 2'd1;
    localparam scan_state_t SEND  = 2'd2;
    localparam scan_state_t FIN   = 2'd3;

    // Rotate-left-by-one then fold in the new word.
    function automatic logic [31:0] csum_step(input logic [31:0] acc, input logic [31:0] d);
        return {acc[30:0], acc[31]} ^ d;
    endfunction

endpackage

// File: rtl/debug_scan_unit.sv
// Walks a window of RF or data memory through Top's debug ports and streams {addr,data} with a checksum.
// Latency: start to first out_valid 2 cycles; 2 cycles/word when out_ready stays high.
// Backpressure: out_valid/out_addr/out_data hold in SEND until out_ready; nothing is re-read during a stall.
module debug_scan_unit
    import debug_scan_unit_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] count,
    output logic [4:0]       debug_addr_RF,
    input  logic [31:0]      debug_data_RF,
    output logic [31:0]      debug_addr_DF,
    input  logic [31:0]      debug_data_DF,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic             done,
    output logic [31:0]      checksum
);

    scan_state_t      state_q, state_d;
    scan_mode_t       mode_q, mode_d;
    logic [31:0]      cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [31:0]      out_addr_q, out_addr_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [31:0]      csum_q, csum_d;
    logic [4:0]       dbg_rf_q, dbg_rf_d;
    logic [31:0]      dbg_df_q, dbg_df_d;

    logic [31:0] next_addr;
    logic [31:0] rd_data;

    assign next_addr = (mode_q == SCAN_DF) ? cur_addr_q + 32'd4
                                           : {27'd0, cur_addr_q[4:0] + 5'd1};
    assign rd_data   = (mode_q == SCAN_DF) ? debug_data_DF : debug_data_RF;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        csum_d      = csum_q;
        dbg_rf_d    = dbg_rf_q;
        dbg_df_d    = dbg_df_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d      = scan_mode_t'(mode);
                    remaining_d = count;
                    csum_d      = 32'd0;
                    if (scan_mode_t'(mode) == SCAN_DF) begin
                        cur_addr_d = {base_addr[31:2], 2'b00};
                        dbg_df_d   = {base_addr[31:2], 2'b00};
                    end else begin
                        cur_addr_d = {27'd0, base_addr[4:0]};
                        dbg_rf_d   = base_addr[4:0];
                    end
                    state_d = (count == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                // Debug address has been stable for a full cycle, so the combinational read is settled.
                out_data_d  = rd_data;
                out_addr_d  = cur_addr_q;
                csum_d      = csum_step(csum_q, rd_data);
                remaining_d = remaining_q - CNT_W'(1);
                state_d     = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (remaining_q != '0) begin
                        cur_addr_d = next_addr;
                        if (mode_q == SCAN_DF) dbg_df_d = next_addr;
                        else                   dbg_rf_d = next_addr[4:0];
                        state_d = ISSUE;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= SCAN_RF;
            cur_addr_q  <= 32'd0;
            remaining_q <= '0;
            out_addr_q  <= 32'd0;
            out_data_q  <= 32'd0;
            csum_q      <= 32'd0;
            dbg_rf_q    <= 5'd0;
            dbg_df_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            csum_q      <= csum_d;
            dbg_rf_q    <= dbg_rf_d;
            dbg_df_q    <= dbg_df_d;
        end
    end

    assign debug_addr_RF = dbg_rf_q;
    assign debug_addr_DF = dbg_df_q;
    assign out_valid     = (state_q == SEND);
    assign out_addr      = out_addr_q;
    assign out_data      = out_data_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FIN);
    assign checksum      = csum_q;

endmodule

// File: tb/tb_debug_scan_unit.sv
// Bench for debug_scan_unit beside a behavioural Top stub (RF = 3*idx+1, DF = addr^A5A5_0000).
module tb_debug_scan_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [31:0] base_addr;
    logic [7:0]  count;
    logic [4:0]  debug_addr_RF;
    logic [31:0] debug_data_RF;
    logic [31:0] debug_addr_DF;
    logic [31:0] debug_data_DF;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    assign debug_data_RF = {27'd0, debug_addr_RF} * 32'd3 + 32'd1;
    assign debug_data_DF = debug_addr_DF ^ 32'hA5A5_0000;

    debug_scan_unit #(.CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .base_addr     (base_addr),
        .count         (count),
        .debug_addr_RF (debug_addr_RF),
        .debug_data_RF (debug_data_RF),
        .debug_addr_DF (debug_addr_DF),
        .debug_data_DF (debug_data_DF),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_addr      (out_addr),
        .out_data      (out_data),
        .busy          (busy),
        .done          (done),
        .checksum      (checksum)
    );

    // stall: 0 = out_ready always high, 1 = random ready and random start noise, 2 = five stall cycles per word
    task automatic do_scan(input bit m, input logic [31:0] base, input int cnt, input int stall,
                           input string tag, output logic [31:0] final_csum);
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        logic [31:0] ecs, a, d, h_addr, h_data;
        int got, first_v, last_hs, stall_cnt, cyc;
        bit held, fin, rdy;
        ecs = 32'd0;
        for (int i = 0; i < cnt; i++) begin
            if (m) a = (base & 32'hFFFF_FFFC) + 32'(4 * i);
            else   a = 32'((int'(base[4:0]) + i) % 32);
            d   = m ? (a ^ 32'hA5A5_0000) : (a * 32'd3 + 32'd1);
            ecs = ((ecs << 1) | (ecs >> 31)) ^ d;
            ea.push_back(a);
            ed.push_back(d);
        end
        got = 0; first_v = -1; last_hs = -1; stall_cnt = 0; held = 0; fin = 0;
        h_addr = 32'd0; h_data = 32'd0;
        @(negedge clk);
        start = 1'b1; mode = m; base_addr = base; count = 8'(cnt);
        @(negedge clk);
        start = 1'b0; base_addr = $urandom; count = 8'($urandom); mode = 1'($urandom_range(0, 1));
        n_checks++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_after_start got=%b exp=1", tag, busy); end
        for (cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (stall == 1) start = 1'($urandom_range(0, 1));
            if (done) begin
                start = 1'b0;
                n_checks++;
                if (got != cnt) begin n_err++; $display("FAIL %s word_count got=%0d exp=%0d", tag, got, cnt); end
                n_checks++;
                if (checksum !== ecs) begin n_err++; $display("FAIL %s checksum got=%h exp=%h", tag, checksum, ecs); end
                if (cnt == 0) begin
                    n_checks++;
                    if (cyc > 1) begin n_err++; $display("FAIL %s zero_count_done_latency got=%0d exp<=1", tag, cyc); end
                end
                @(negedge clk);
                n_checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    n_err++; $display("FAIL %s done_one_cycle done=%b busy=%b exp=0,0", tag, done, busy);
                end
                n_checks++;
                if (checksum !== ecs) begin n_err++; $display("FAIL %s checksum_hold got=%h exp=%h", tag, checksum, ecs); end
                fin = 1;
            end else if (out_valid) begin
                if (first_v < 0) begin
                    first_v = cyc;
                    n_checks++;
                    if (cyc != 1) begin n_err++; $display("FAIL %s first_valid_latency got=%0d exp=1", tag, cyc); end
                end
                if (held) begin
                    n_checks++;
                    if (out_addr !== h_addr || out_data !== h_data) begin
                        n_err++; $display("FAIL %s stall_stable got=%h/%h exp=%h/%h", tag, out_addr, out_data, h_addr, h_data);
                    end
                end
                case (stall)
                    0:       rdy = 1'b1;
                    1:       rdy = ($urandom_range(0, 2) == 0);
                    default: rdy = (stall_cnt >= 5);
                endcase
                out_ready = rdy;
                if (rdy) begin
                    n_checks++;
                    if (got >= cnt) begin
                        n_err++; $display("FAIL %s extra_word got=%h/%h exp=none", tag, out_addr, out_data);
                    end else if (out_addr !== ea[got] || out_data !== ed[got]) begin
                        n_err++; $display("FAIL %s word%0d got=%h/%h exp=%h/%h", tag, got, out_addr, out_data, ea[got], ed[got]);
                    end
                    if (stall == 0 && last_hs >= 0) begin
                        n_checks++;
                        if (cyc - last_hs != 2) begin n_err++; $display("FAIL %s throughput got=%0d exp=2", tag, cyc - last_hs); end
                    end
                    last_hs = cyc; got++; held = 0; stall_cnt = 0;
                end else begin
                    held = 1; h_addr = out_addr; h_data = out_data; stall_cnt++;
                end
            end else begin
                if (held) begin
                    n_checks++; n_err++; $display("FAIL %s valid_dropped got=0 exp=1", tag);
                end
                held = 0;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        if (!fin) begin
            n_checks++; n_err++; $display("FAIL %s timeout got=no_done exp=done", tag);
        end
        start = 1'b0;
        final_csum = checksum;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; base_addr = 32'd0; count = 8'd0; out_ready = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, done, out_addr, out_data, checksum, debug_addr_RF, debug_addr_DF} !== '0) begin
            n_err++; $display("FAIL reset_state got v=%b b=%b d=%b a=%h dat=%h cs=%h rf=%h df=%h exp=all0",
                              out_valid, busy, done, out_addr, out_data, checksum, debug_addr_RF, debug_addr_DF);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] cs;
        do_scan(1'b0, 32'd0, 2, 0, "rf_base0", cs);
        n_checks++;
        if (cs !== 32'h6) begin n_err++; $display("FAIL rf_base0_const got=%h exp=00000006", cs); end
        do_scan(1'b0, 32'd31, 2, 0, "rf_wrap", cs);
        n_checks++;
        if (cs !== 32'hBD) begin n_err++; $display("FAIL rf_wrap_const got=%h exp=000000bd", cs); end
        do_scan(1'b1, 32'hFFFF_FFFC, 2, 0, "df_wrap", cs);
        do_scan(1'b1, 32'h0000_1003, 3, 0, "df_unaligned", cs);
    endtask

    task automatic test_backpressure();
        logic [31:0] cs;
        do_scan(1'b0, 32'd0, 3, 2, "backpressure", cs);
    endtask

    task automatic test_zero_count();
        logic [31:0] cs;
        do_scan(1'b1, 32'h40, 0, 0, "count0", cs);
        n_checks++;
        if (cs !== 32'd0) begin n_err++; $display("FAIL count0_csum got=%h exp=0", cs); end
    endtask

    task automatic test_random();
        logic [31:0] cs;
        for (int t = 0; t < 8; t++)
            do_scan(1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 45)), 1, $sformatf("rand%0d", t), cs);
        do_scan(1'b0, 32'd7, 255, 0, "rf_max_count", cs);
    endtask

    task automatic test_reset_mid_scan();
        logic [31:0] cs;
        int seen;
        seen = 0;
        @(negedge clk);
        start = 1'b1; mode = 1'b0; base_addr = 32'd0; count = 8'd4;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 30 && seen < 2; k++) begin
            @(negedge clk);
            if (out_valid) begin
                seen++;
                out_ready = (seen == 1);
            end
        end
        n_checks++;
        if (seen != 2) begin n_err++; $display("FAIL midreset_reach_send got=%0d exp=2", seen); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, done, out_addr, out_data, checksum, debug_addr_RF, debug_addr_DF} !== '0) begin
            n_err++; $display("FAIL midreset_async got v=%b b=%b d=%b a=%h dat=%h cs=%h exp=all0",
                              out_valid, busy, done, out_addr, out_data, checksum);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midreset_idle done=%b busy=%b exp=0,0", done, busy); end
        rst_n = 1'b1;
        out_ready = 1'b1;
        do_scan(1'b0, 32'd0, 4, 0, "after_reset", cs);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_zero_count();
        test_random();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
